// File: rtl/bram_arbiter_pkg.sv
// rtl/bram_arbiter_pkg.sv - shared memory access codes, response tags and helpers
package bram_arbiter_pkg;

   localparam logic [4:0] ACC_NOOP    = 5'b0_0000;
   localparam logic [4:0] ACC_RD_WORD = 5'b0_1111;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_IF   = 2'd1,
      TAG_D    = 2'd2
   } rsp_tag_e;

   // Only full-word accesses carry an alignment requirement.
   function automatic logic word_misaligned(input logic [3:0] be, input logic [1:0] addr_lo);
      return (be == 4'hF) && (addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/bram_arb_priority.sv
// rtl/bram_arb_priority.sv - data-first grant decision with fetch starvation guard
module bram_arb_priority
   import bram_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic if_valid_i,
   input  logic d_valid_i,
   output logic grant_if_o,
   output logic grant_d_o
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_q, starve_d;
   logic          starved;

   assign starved = (starve_q >= LIMIT);

   always_comb begin
      grant_if_o = resetn_i && if_valid_i && (!d_valid_i || starved);
      grant_d_o  = resetn_i && d_valid_i && !grant_if_o;
      starve_d   = starve_q;
      // Count saturates so a waiting fetch stays eligible until it wins.
      if (!if_valid_i || grant_if_o) begin
         starve_d = '0;
      end else if (grant_d_o && !starved) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-port (fetch/data) arbiter in front of a single BRAM addresser
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   input  logic        d_req_valid,
   input  logic [4:0]  d_req_code,
   input  logic [31:0] d_req_addr,
   input  logic [31:0] d_req_wdata,
   output logic        d_req_ready,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_data,
   output logic [4:0]  mem_access_code,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_to_store,
   input  logic [31:0] mem_writeback_data,
   output logic        misalign_err
);

   logic     grant_if, grant_d;
   logic     if_mis, d_noop, d_mis, d_read;
   rsp_tag_e tag_q, tag_d;
   logic     zero_q, zero_d;

   bram_arb_priority #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_priority (
      .clk_i      (CLOCK_50),
      .resetn_i   (resetn),
      .if_valid_i (if_req_valid),
      .d_valid_i  (d_req_valid),
      .grant_if_o (grant_if),
      .grant_d_o  (grant_d)
   );

   assign if_req_ready = grant_if;
   assign d_req_ready  = grant_d;

   assign if_mis = word_misaligned(4'hF, if_req_addr[1:0]);
   assign d_noop = (d_req_code[3:0] == 4'h0);
   assign d_mis  = word_misaligned(d_req_code[3:0], d_req_addr[1:0]);
   assign d_read = !d_req_code[4] && !d_noop;

   always_comb begin
      mem_access_code   = ACC_NOOP;
      mem_address       = '0;
      mem_data_to_store = '0;
      misalign_err      = 1'b0;
      tag_d             = TAG_NONE;
      zero_d            = 1'b0;
      if (grant_if) begin
         tag_d  = TAG_IF;
         zero_d = if_mis;
         if (if_mis) begin
            misalign_err = 1'b1;
         end else begin
            mem_access_code = ACC_RD_WORD;
            mem_address     = if_req_addr;
         end
      end else if (grant_d && !d_noop) begin
         if (d_mis) begin
            misalign_err = 1'b1;
         end else begin
            mem_access_code   = d_req_code;
            mem_address       = d_req_addr;
            mem_data_to_store = d_req_wdata;
         end
         if (d_read) begin
            tag_d  = TAG_D;
            zero_d = d_mis;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         tag_q  <= TAG_NONE;
         zero_q <= 1'b0;
      end else begin
         tag_q  <= tag_d;
         zero_q <= zero_d;
      end
   end

   // Gated by resetn so a read issued just before reset never surfaces.
   assign if_rsp_valid = resetn && (tag_q == TAG_IF);
   assign d_rsp_valid  = resetn && (tag_q == TAG_D);
   assign if_rsp_data  = (if_rsp_valid && !zero_q) ? mem_writeback_data : '0;
   assign d_rsp_data   = (d_rsp_valid && !zero_q) ? mem_writeback_data : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - directed and randomized self-checking bench for bram_arbiter
module tb_bram_arbiter;

   localparam int LIMIT = 4;

   logic        CLOCK_50 = 1'b0;
   logic        resetn;
   logic        if_req_valid;
   logic [31:0] if_req_addr;
   logic        if_req_ready, if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        d_req_valid;
   logic [4:0]  d_req_code;
   logic [31:0] d_req_addr, d_req_wdata;
   logic        d_req_ready, d_rsp_valid;
   logic [31:0] d_rsp_data;
   logic [4:0]  mem_access_code;
   logic [31:0] mem_address, mem_data_to_store;
   logic [31:0] mem_writeback_data = '0;
   logic        misalign_err;

   always #5 CLOCK_50 = ~CLOCK_50;

   bram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .CLOCK_50           (CLOCK_50),
      .resetn             (resetn),
      .if_req_valid       (if_req_valid),
      .if_req_addr        (if_req_addr),
      .if_req_ready       (if_req_ready),
      .if_rsp_valid       (if_rsp_valid),
      .if_rsp_data        (if_rsp_data),
      .d_req_valid        (d_req_valid),
      .d_req_code         (d_req_code),
      .d_req_addr         (d_req_addr),
      .d_req_wdata        (d_req_wdata),
      .d_req_ready        (d_req_ready),
      .d_rsp_valid        (d_rsp_valid),
      .d_rsp_data         (d_rsp_data),
      .mem_access_code    (mem_access_code),
      .mem_address        (mem_address),
      .mem_data_to_store  (mem_data_to_store),
      .mem_writeback_data (mem_writeback_data),
      .misalign_err       (misalign_err)
   );

   // BRAM addresser stand-in: byte-enabled writes, one-cycle read latency.
   logic [31:0] bram [0:63];
   always @(posedge CLOCK_50) begin
      if (mem_access_code[3:0] != 4'h0) begin
         if (mem_access_code[4]) begin
            for (int b = 0; b < 4; b++)
               if (mem_access_code[b]) bram[mem_address[7:2]][8*b +: 8] <= mem_data_to_store[8*b +: 8];
         end else begin
            mem_writeback_data <= bram[mem_address[7:2]];
         end
      end
   end

   // Reference model state
   logic [31:0] ref_mem [0:63];
   int          starve;
   bit          pend_if, pend_d;
   logic [31:0] pend_if_data, pend_d_data;
   bit          last_gif, last_gd;
   int          errors, checks;
   logic [4:0]  codes [6] = '{5'h0F, 5'h1F, 5'h00, 5'h13, 5'h03, 5'h10};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      if_req_valid = 1'b0; if_req_addr = '0;
      d_req_valid  = 1'b0; d_req_code  = '0; d_req_addr = '0; d_req_wdata = '0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   // One cycle: inputs already driven; check every output against the model, advance it.
   task automatic step();
      bit gif, gd, mis, noop, rd, eerr, npi, npd;
      logic [4:0]  ecode;
      logic [31:0] eaddr, edata, npid, npdd;
      #1;
      gif = 0; gd = 0; eerr = 0; npi = 0; npd = 0; npid = '0; npdd = '0;
      ecode = 5'b0_0000; eaddr = '0; edata = '0;
      if (resetn) begin
         gif = if_req_valid && (!d_req_valid || starve >= LIMIT);
         gd  = d_req_valid && !gif;
         if (gif) begin
            mis = (if_req_addr[1:0] != 2'b00);
            npi = 1; eerr = mis;
            npid = mis ? 32'h0 : ref_mem[if_req_addr[7:2]];
            if (!mis) begin ecode = 5'b0_1111; eaddr = if_req_addr; end
         end else if (gd) begin
            noop = (d_req_code[3:0] == 4'h0);
            mis  = (d_req_code[3:0] == 4'hF) && (d_req_addr[1:0] != 2'b00);
            rd   = !d_req_code[4] && !noop;
            eerr = mis;
            npd  = rd;
            npdd = mis ? 32'h0 : ref_mem[d_req_addr[7:2]];
            if (!noop && !mis) begin
               ecode = d_req_code; eaddr = d_req_addr; edata = d_req_wdata;
               if (d_req_code[4])
                  for (int b = 0; b < 4; b++)
                     if (d_req_code[b]) ref_mem[d_req_addr[7:2]][8*b +: 8] = d_req_wdata[8*b +: 8];
            end
         end
      end
      chk("if_req_ready", 32'(if_req_ready), 32'(gif));
      chk("d_req_ready", 32'(d_req_ready), 32'(gd));
      chk("if_rsp_valid", 32'(if_rsp_valid), 32'(resetn && pend_if));
      chk("d_rsp_valid", 32'(d_rsp_valid), 32'(resetn && pend_d));
      if (resetn && pend_if) chk("if_rsp_data", if_rsp_data, pend_if_data);
      if (resetn && pend_d) chk("d_rsp_data", d_rsp_data, pend_d_data);
      chk("mem_access_code", 32'(mem_access_code), 32'(ecode));
      chk("mem_address", mem_address, eaddr);
      chk("mem_data_to_store", mem_data_to_store, edata);
      chk("misalign_err", 32'(misalign_err), 32'(eerr));
      if (!resetn || !if_req_valid || gif) starve = 0;
      else if (gd && starve < LIMIT) starve++;
      pend_if = npi; pend_if_data = npid;
      pend_d  = npd; pend_d_data  = npdd;
      last_gif = gif; last_gd = gd;
      @(negedge CLOCK_50);
   endtask

   initial begin
      errors = 0; checks = 0; starve = 0;
      pend_if = 0; pend_d = 0; pend_if_data = '0; pend_d_data = '0;
      last_gif = 0; last_gd = 0;
      for (int i = 0; i < 64; i++) begin
         bram[i] = $urandom; ref_mem[i] = bram[i];
      end
      resetn = 1'b0;
      set_idle();
      @(negedge CLOCK_50);

      // Reset with both requesters active: nothing granted, no-op on memory
      if_req_valid = 1; d_req_valid = 1; d_req_code = 5'h0F;
      step(); step();
      resetn = 1'b1; set_idle();
      step();

      // Store then fetch the same word
      d_req_valid = 1; d_req_code = 5'h1F; d_req_addr = 0; d_req_wdata = 32'hF0F1F2F3;
      step();
      set_idle(); if_req_valid = 1; if_req_addr = 0;
      #1 chk("fetch_grant", 32'(if_req_ready), 32'd1);
      step();
      set_idle();
      #1 chk("fetch_rsp_data", if_rsp_data, 32'hF0F1F2F3);
      step();

      // Back-to-back data reads
      d_req_valid = 1; d_req_code = 5'h1F; d_req_addr = 4; d_req_wdata = 32'hA0A1A2A3;
      step();
      d_req_code = 5'h0F; d_req_addr = 0;
      step();
      d_req_addr = 4;
      #1 chk("b2b_rsp0_valid", 32'(d_rsp_valid), 32'd1);
      chk("b2b_rsp0_data", d_rsp_data, 32'hF0F1F2F3);
      step();
      set_idle();
      #1 chk("b2b_rsp1_valid", 32'(d_rsp_valid), 32'd1);
      chk("b2b_rsp1_data", d_rsp_data, 32'hA0A1A2A3);
      step();

      // Continuous contention: D,D,D,D,IF repeating
      if_req_valid = 1; if_req_addr = 8; d_req_valid = 1; d_req_code = 5'h0F; d_req_addr = 12;
      for (int i = 0; i < 15; i++) begin
         #1 chk("starve_pattern", 32'(if_req_ready), 32'(i % 5 == 4));
         step();
      end
      set_idle();
      step();

      // Misaligned word read
      d_req_valid = 1; d_req_code = 5'h0F; d_req_addr = 2;
      #1 chk("misalign_pulse", 32'(misalign_err), 32'd1);
      chk("misalign_mem_code", 32'(mem_access_code), 32'd0);
      step();
      set_idle();
      #1 chk("misalign_rsp_valid", 32'(d_rsp_valid), 32'd1);
      chk("misalign_rsp_data", d_rsp_data, 32'd0);
      step();

      // Fetch issued, then reset on the next edge
      if_req_valid = 1; if_req_addr = 16;
      step();
      resetn = 1'b0; set_idle();
      #1 chk("reset_drop_rsp", 32'(if_rsp_valid), 32'd0);
      step(); step();
      resetn = 1'b1;
      #1 chk("after_reset_rsp", 32'(if_rsp_valid), 32'd0);
      step();

      // No-op data request
      d_req_valid = 1; d_req_code = 5'h00; d_req_addr = 20;
      #1 chk("noop_ready", 32'(d_req_ready), 32'd1);
      chk("noop_mem_code", 32'(mem_access_code), 32'd0);
      step();
      set_idle();
      #1 chk("noop_no_rsp", 32'(d_rsp_valid), 32'd0);
      step();

      // Randomized traffic; un-granted requests are held stable
      for (int n = 0; n < 400; n++) begin
         if (!(if_req_valid && !last_gif)) begin
            if_req_valid = ($urandom_range(0, 3) != 0);
            if_req_addr  = rand_addr();
         end
         if (!(d_req_valid && !last_gd)) begin
            d_req_valid = ($urandom_range(0, 3) != 0);
            d_req_code  = codes[$urandom_range(0, 5)];
            d_req_addr  = rand_addr();
            d_req_wdata = $urandom;
         end
         resetn = ($urandom_range(0, 63) != 0);
         step();
      end
      resetn = 1'b1; set_idle();
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
